// File: rtl/io_bus_responder.sv
// IO bus responder: decodes CPU IO bus, holds LED/segment registers, returns switch/button input (optional IO_CYCLE_CNT_EN adds cycle counter at 0x18).
// Latency: writes visible one cycle after the write edge; io_din is combinational from io_addr; button press -> in_valid in DEBOUNCE_CYC+3 cycles.
// Backpressure: segment writes while out_ready=0 are dropped and flagged in out_drop; presses while in_valid=1 are dropped and flagged in in_ovf.
module io_bus_responder #(
    parameter int DEBOUNCE_CYC = 16,
    parameter int DISP_HOLD    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  io_addr,
    input  logic [31:0] io_dout,
    input  logic        io_we,
    output logic [31:0] io_din,
    input  logic [15:0] sw,
    input  logic        btn,
    output logic [15:0] led,
    output logic [31:0] seg_data
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int HOLD_W = $clog2(DISP_HOLD + 1);

    localparam logic [7:0] ADDR_LED      = 8'h00;
    localparam logic [7:0] ADDR_STAT_OUT = 8'h04;
    localparam logic [7:0] ADDR_SEG      = 8'h08;
    localparam logic [7:0] ADDR_STAT_IN  = 8'h0C;
    localparam logic [7:0] ADDR_IN_DATA  = 8'h10;
    localparam logic [7:0] ADDR_SW       = 8'h14;
    localparam logic [7:0] ADDR_CYC      = 8'h18;

    logic              out_ready;
    logic              out_drop;
    logic [HOLD_W-1:0] hold_cnt;

    logic              in_valid;
    logic              in_ovf;
    logic [15:0]       in_data;

    logic              btn_s1;
    logic              btn_s2;
    logic [DB_W-1:0]   db_cnt;
    logic              db_lvl;
    logic              db_lvl_q;
    logic              press;

    logic              wr_led;
    logic              wr_stat_out;
    logic              wr_seg;
    logic              wr_stat_in;

    assign wr_led      = io_we && (io_addr == ADDR_LED);
    assign wr_stat_out = io_we && (io_addr == ADDR_STAT_OUT);
    assign wr_seg      = io_we && (io_addr == ADDR_SEG);
    assign wr_stat_in  = io_we && (io_addr == ADDR_STAT_IN);

    // Press is the rising edge of the debounced level, exactly one cycle wide.
    assign press = db_lvl & ~db_lvl_q;

    // LED register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= '0;
        end else if (wr_led) begin
            led <= io_dout[15:0];
        end
    end

    // Segment register with display hold timer; writes during the hold are dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_data  <= '0;
            out_ready <= 1'b1;
            out_drop  <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
                if (hold_cnt == HOLD_W'(1)) begin
                    out_ready <= 1'b1;
                end
            end
            // out_ready=1 implies hold_cnt=0, so an accepted write never races the expiry above.
            if (wr_seg) begin
                if (out_ready) begin
                    seg_data  <= io_dout;
                    out_ready <= 1'b0;
                    hold_cnt  <= HOLD_W'(DISP_HOLD);
                end else begin
                    out_drop  <= 1'b1;
                end
            end else if (wr_stat_out) begin
                out_drop <= 1'b0;
            end
        end
    end

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
        end
    end

    // Debounce: flip the level after DEBOUNCE_CYC consecutive mismatching cycles; any match restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt   <= '0;
            db_lvl   <= 1'b0;
            db_lvl_q <= 1'b0;
        end else begin
            db_lvl_q <= db_lvl;
            if (btn_s2 != db_lvl) begin
                if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
                    db_lvl <= btn_s2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Input capture: a status clear on the same edge takes effect before the press is applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_valid <= 1'b0;
            in_ovf   <= 1'b0;
            in_data  <= '0;
        end else begin
            if (press) begin
                if (in_valid && !wr_stat_in) begin
                    in_ovf <= 1'b1;
                end else begin
                    in_valid <= 1'b1;
                    in_data  <= sw;
                    in_ovf   <= 1'b0;
                end
            end else if (wr_stat_in) begin
                in_valid <= 1'b0;
                in_ovf   <= 1'b0;
            end
        end
    end

`ifdef IO_CYCLE_CNT_EN
    logic [31:0] cyc_cnt;

    // Free-running cycle counter; a write to its address restarts it from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
        end else if (io_we && (io_addr == ADDR_CYC)) begin
            cyc_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
        end
    end
`endif

    // Read mux, combinational from the address; unmapped addresses read zero.
    always_comb begin
        io_din = '0;
        case (io_addr)
            ADDR_LED:      io_din = {16'b0, led};
            ADDR_STAT_OUT: io_din = {30'b0, out_drop, out_ready};
            ADDR_SEG:      io_din = seg_data;
            ADDR_STAT_IN:  io_din = {30'b0, in_ovf, in_valid};
            ADDR_IN_DATA:  io_din = {16'b0, in_data};
            ADDR_SW:       io_din = {16'b0, sw};
`ifdef IO_CYCLE_CNT_EN
            ADDR_CYC:      io_din = cyc_cnt;
`endif
            default:       io_din = '0;
        endcase
    end

endmodule

// File: tb/tb_io_bus_responder.sv
// Testbench for io_bus_responder: directed scenarios plus randomized traffic against a behavioural model.
// Latency: model advances once per clock edge alongside the design.
// Backpressure: none; the bench drives every cycle.
module tb_io_bus_responder;

    localparam int DB   = 4;
    localparam int HOLD = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  addr;
    logic [31:0] dout;
    logic        we;
    logic [31:0] din;
    logic [15:0] sw;
    logic        btn;
    logic [15:0] led;
    logic [31:0] seg;

    int n_checks = 0;
    int n_errors = 0;

    io_bus_responder #(.DEBOUNCE_CYC(DB), .DISP_HOLD(HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .io_addr  (addr),
        .io_dout  (dout),
        .io_we    (we),
        .io_din   (din),
        .sw       (sw),
        .btn      (btn),
        .led      (led),
        .seg_data (seg)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [15:0] m_led;
    logic [31:0] m_seg;
    bit          m_ready, m_drop;
    int          m_hold;
    bit          m_valid, m_ovf;
    logic [15:0] m_data;
    logic [31:0] m_cyc;
    bit          m_db, m_press;
    int          m_run;
    bit          btn_d1, btn_d2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_led = '0; m_seg = '0; m_ready = 1; m_drop = 0; m_hold = 0;
        m_valid = 0; m_ovf = 0; m_data = '0; m_cyc = '0;
        m_db = 0; m_press = 0; m_run = 0; btn_d1 = 0; btn_d2 = 0;
    endtask

    // One clock edge of the specified behaviour, using the inputs currently applied.
    task automatic step_model();
        bit old_ready;
        bit cyc_clr;
        old_ready = m_ready;
        cyc_clr = 0;
        if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) m_ready = 1;
        end
        if (we) begin
            case (addr)
                8'h00: m_led = dout[15:0];
                8'h04: m_drop = 0;
                8'h08: begin
                    if (old_ready) begin
                        m_seg = dout; m_ready = 0; m_hold = HOLD;
                    end else begin
                        m_drop = 1;
                    end
                end
                8'h0C: begin m_valid = 0; m_ovf = 0; end
                8'h18: cyc_clr = 1;
                default: ;
            endcase
        end
        if (m_press) begin
            if (m_valid) m_ovf = 1;
            else begin m_valid = 1; m_data = sw; end
        end
        m_cyc = cyc_clr ? 32'd0 : m_cyc + 32'd1;
        // Button seen two edges late; level flips after DB consecutive differing samples.
        m_press = 0;
        if (btn_d2 != m_db) begin
            m_run++;
            if (m_run == DB) begin
                m_db = btn_d2; m_run = 0; m_press = m_db;
            end
        end else begin
            m_run = 0;
        end
        btn_d2 = btn_d1;
        btn_d1 = btn;
    endtask

    function automatic logic [31:0] exp_read(input logic [7:0] a);
        case (a)
            8'h00: return {16'b0, m_led};
            8'h04: return {30'b0, m_drop, m_ready};
            8'h08: return m_seg;
            8'h0C: return {30'b0, m_ovf, m_valid};
            8'h10: return {16'b0, m_data};
            8'h14: return {16'b0, sw};
`ifdef IO_CYCLE_CNT_EN
            8'h18: return m_cyc;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else step_model();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        addr = a; dout = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, din, exp);
    endtask

    initial begin
        int btn_left;
        logic [7:0] amap [7];
        amap = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18};

        rst_n = 1'b0; addr = '0; dout = '0; we = 1'b0; sw = '0; btn = 1'b0;
        model_reset();
        ticks(3);
        rst_n = 1'b1;

        // Reset state
        rd_chk("rst_stat_out", 8'h04, 32'h1);
        rd_chk("rst_stat_in", 8'h0C, 32'h0);
        check("rst_led", {16'b0, led}, 32'h0);
        check("rst_seg", seg, 32'h0);

        // LED write
        wr(8'h00, 32'hABCD1234);
        check("led_out", {16'b0, led}, 32'h1234);
        rd_chk("led_rd", 8'h00, 32'h00001234);

        // Segment write and hold window
        wr(8'h08, 32'hDEADBEEF);
        check("seg_out", seg, 32'hDEADBEEF);
        for (int i = 0; i < HOLD; i++) begin
            rd_chk("hold_busy", 8'h04, 32'h0);
            tick();
        end
        rd_chk("hold_done", 8'h04, 32'h1);

        // Dropped write during hold
        wr(8'h08, 32'h11111111);
        wr(8'h08, 32'h22222222);
        check("drop_seg", seg, 32'h11111111);
        rd_chk("drop_stat", 8'h04, 32'h2);
        ticks(3);
        rd_chk("drop_ready", 8'h04, 32'h3);
        wr(8'h04, 32'h0);
        rd_chk("drop_clr", 8'h04, 32'h1);

        // Reset in the middle of a hold
        wr(8'h08, 32'h5555AAAA);
        tick();
        rd_chk("mid_hold", 8'h04, 32'h0);
        rst_n = 1'b0;
        model_reset();
        #1;
        rd_chk("rst_mid_hold", 8'h04, 32'h1);
        check("rst_mid_seg", seg, 32'h0);
        tick();
        rst_n = 1'b1;

        // Glitch shorter than the debounce window
        sw = 16'h00A5;
        btn = 1'b1;
        ticks(DB - 1);
        btn = 1'b0;
        ticks(10);
        rd_chk("glitch", 8'h0C, 32'h0);

        // Held press: exact latency
        btn = 1'b1;
        for (int i = 1; i <= DB + 3; i++) begin
            tick();
            if (i == DB + 2) rd_chk("lat_early", 8'h0C, 32'h0);
        end
        rd_chk("lat_valid", 8'h0C, 32'h1);
        rd_chk("in_data", 8'h10, 32'h000000A5);
        btn = 1'b0;
        ticks(10);
        rd_chk("release", 8'h0C, 32'h1);

        // Overflow while valid
        sw = 16'h0077;
        btn = 1'b1;
        ticks(10);
        btn = 1'b0;
        ticks(10);
        rd_chk("ovf_stat", 8'h0C, 32'h3);
        rd_chk("ovf_data", 8'h10, 32'h000000A5);

        // Clear on the same edge as a press
        sw = 16'h0042;
        btn = 1'b1;
        ticks(DB + 2);
        wr(8'h0C, 32'hFFFFFFFF);
        rd_chk("same_edge_stat", 8'h0C, 32'h1);
        rd_chk("same_edge_data", 8'h10, 32'h00000042);
        btn = 1'b0;
        ticks(10);

        // Cycle counter
`ifdef IO_CYCLE_CNT_EN
        wr(8'h18, 32'h0);
        rd_chk("cyc_zero", 8'h18, 32'h0);
        ticks(5);
        rd_chk("cyc_n", 8'h18, 32'd5);
`else
        rd_chk("cyc_off", 8'h18, 32'h0);
        wr(8'h18, 32'h12345678);
        rd_chk("cyc_off_wr", 8'h18, 32'h0);
`endif

        // Randomized traffic against the model
        btn_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check("rand_rst_led", {16'b0, led}, 32'h0);
                tick();
                rst_n = 1'b1;
            end
            if (btn_left == 0) begin
                btn = ~btn;
                btn_left = $urandom_range(1, 10);
            end
            btn_left--;
            if ($urandom_range(0, 7) == 0) sw = 16'($urandom);
            we = ($urandom_range(0, 3) == 0);
            dout = $urandom;
            if ($urandom_range(0, 7) == 7) addr = 8'($urandom);
            else addr = amap[$urandom_range(0, 6)];
            #1;
            check("rand_din", din, exp_read(addr));
            check("rand_led", {16'b0, led}, {16'b0, m_led});
            check("rand_seg", seg, m_seg);
            tick();
        end
        we = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/io_bus_responder.md
Name: io_bus_responder

Overview:
- Peripheral-side responder for the CPU IO bus: decodes `io_addr`/`io_we`, holds LED and seven-segment output registers, and returns switch/button input on `io_din`.
- Software handshakes both directions through status registers:
  - output-ready flag with a display hold timer;
  - input-valid flag set by a debounced button press.
- Sits between the pipelined CPU's IO bus and board LEDs, segment driver, switches and step button.

Parameters:
- DEBOUNCE_CYC, 16, consecutive stable cycles the synced button needs before its debounced level changes (>=1).
- DISP_HOLD, 8, cycles `out_ready` stays low after an accepted segment write (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- io_addr  in  8  byte address from CPU.
- io_dout  in  32  write data from CPU.
- io_we  in  1  write strobe, one write per asserted cycle.
- io_din  out  32  read data to CPU, combinational from io_addr.
- sw  in  16  raw switches (quasi-static, not synchronized).
- btn  in  1  raw step button, asynchronous.
- led  out  16  LED register.
- seg_data  out  32  segment display value (8 hex digits).

Behaviour:
- Reset (async, rst_n=0):
  - led=0, seg_data=0.
  - out_ready=1, out_drop=0, hold counter=0.
  - in_valid=0, in_ovf=0, in_data=0.
  - Sync flops and debounce state =0.
  - Reset mid-hold or mid-debounce aborts; no pending event survives.
- Address map (reads return zero-extended values; unlisted addresses read 0 and ignore writes):
  - 0x00 R/W led. Write loads io_dout[15:0].
  - 0x04 R status_out = {30'b0, out_drop, out_ready}. Write clears out_drop.
  - 0x08 R/W seg_data.
    - Write with out_ready=1: load io_dout, out_ready<=0, counter<=DISP_HOLD.
    - Write with out_ready=0: dropped, out_drop<=1.
  - 0x0C R status_in = {30'b0, in_ovf, in_valid}. Write (any data) clears in_valid and in_ovf.
  - 0x10 R in_data (16 bits).
  - 0x14 R live sw.
- Write timing: writes take effect on the clock edge where io_we=1; the new value is visible on the outputs the next cycle.
- Hold counter:
  - Decrements each cycle while nonzero.
  - Transition 1->0 sets out_ready=1 on the same edge.
  - An accepted 0x08 write on the expiring cycle is impossible, because out_ready is still 0 and the write is dropped.
- Button path:
  - 2-FF synchronizer, then stable counter.
  - When the synced level differs from the debounced level for DEBOUNCE_CYC consecutive cycles, the debounced level flips and the counter restarts on any mismatch break.
  - A press event is the debounced 0->1 edge, one-cycle pulse.
  - Latency from btn rise (held) to in_valid=1: DEBOUNCE_CYC+3 cycles exactly.
- Press event:
  - If in_valid=0: in_data<=sw, in_valid<=1.
  - If in_valid=1: in_ovf<=1, in_data unchanged.
  - Press event on the same edge as a 0x0C write: the clear applies first, then the event. Result: in_valid=1, in_data=sw, in_ovf=0.
- Button release produces no event. Glitches shorter than DEBOUNCE_CYC produce none.

Optional Feature:
- Macro: IO_CYCLE_CNT_EN.
- Defined:
  - 32-bit free-running cycle counter at 0x18, reset 0, +1 per cycle, wraps 0xFFFFFFFF->0.
  - Write to 0x18 clears it to 0 (counts from 1 next cycle).
- Undefined: 0x18 reads 0, writes ignored, no counter logic.

Test Plan (DEBOUNCE_CYC=4, DISP_HOLD=3):
- Reset: after reset release, read 0x04 -> 0x1, 0x0C -> 0x0, led=0, seg_data=0. Assert rst_n low mid-hold -> out_ready returns to 1 immediately.
- LED/seg:
  - Write 0x00 data 0xABCD1234 -> led=0x1234, read 0x00 -> 0x00001234.
  - Write 0x08 data 0xDEADBEEF -> seg_data=0xDEADBEEF, status_out=0x0 for 3 cycles, then 0x1.
- Drop:
  - Write 0x08 0x11111111, then on the next cycle write 0x08 0x22222222 -> seg_data stays 0x11111111, status_out=0x2.
  - Write 0x04 -> out_drop cleared.
- Debounce: sw=0x00A5, btn pulses high for 3 cycles -> no event. btn held high -> in_valid=1 exactly 7 cycles after rise, read 0x10 -> 0x000000A5.
- Overflow/clear:
  - Second press with sw=0x0077 while valid -> status_in=0x3, in_data still 0xA5.
  - Write 0x0C on the same edge as a new press with sw=0x0042 -> status_in=0x1, in_data=0x42.
- IO_CYCLE_CNT_EN:
  - Write 0x18, read it N cycles later -> N.
  - Force counter to 0xFFFFFFFF -> reads 0 the next cycle.
  - Macro undefined -> 0x18 reads 0.
